// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the scoreboarded hazard unit.
//   fwd_sel_t   : ALU operand forwarding select encoding
//   mc_state_t  : occupancy state of the multi-cycle (MUL/DIV) unit
//   HU_*        : default widths used by hazard_unit_sb and hazard_scoreboard
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int HU_REG_ADDR_W = 5;
    localparam int HU_NUM_REGS   = 2 ** HU_REG_ADDR_W;
    localparam int HU_CNT_W      = 16;

    // Forwarding select encoding. The bit pattern is fixed by the datapath
    // mux, so it is a plain two-bit type with named values.
    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_MC  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// One busy bit per architectural register, marking destinations whose value
// is still being produced by the multi-cycle unit.
// Ports:
//   clk, rst           clock, asynchronous active-high reset (clears all bits)
//   set_en, set_key    mark a register busy (multi-cycle issue)
//   clr_en, clr_key    mark a register free (multi-cycle completion)
//   rd1_key, rd2_key   decode source keys to look up
//   rd1_busy, rd2_busy lookup results; a key being cleared this cycle and
//                      key 0 both read as not busy
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HU_REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_key,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_key,
    input  logic [REG_ADDR_W-1:0] rd1_key,
    input  logic [REG_ADDR_W-1:0] rd2_key,
    output logic                  rd1_busy,
    output logic                  rd2_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    // Next-state of the busy vector. The clear is applied first so that a
    // set of the same key on the same edge wins: a back-to-back op writing
    // the register its predecessor just finished must keep it busy. Entry 0
    // is forced clear because x0 is never written.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_key] = 1'b0;
        end
        if (set_en && (set_key != '0)) begin
            busy_nxt[set_key] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Busy vector register, cleared asynchronously so a reset in the middle
    // of a multi-cycle operation forgets every outstanding destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // A result completing this cycle is forwarded straight to the consumer,
    // so its key is treated as already free for the lookup.
    assign rd1_busy = (rd1_key != '0) && busy[rd1_key] && !(clr_en && (clr_key == rd1_key));
    assign rd2_busy = (rd2_key != '0) && busy[rd2_key] && !(clr_en && (clr_key == rd2_key));

endmodule

// File: rtl/hazard_unit_sb.sv
// ---------------------------------------------------------------------------
// hazard_unit_sb
// Hazard unit for a 5-stage pipeline with an attached variable-latency
// multi-cycle unit (MUL/DIV). Produces ALU forwarding selects, load-use,
// scoreboard RAW and structural stalls, branch flushes, the multi-cycle
// occupancy state and a saturating stall-cycle counter.
//
// Optional build macro HU_MC_FLUSH_EN: when defined, a multi-cycle issue
// presented the cycle after a taken branch is treated as wrong-path and
// dropped (no busy bit, no FSM transition). When undefined, every issue is
// honoured and the pipeline must squash wrong-path issues itself.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   d_in_r1_key/r2_key             decode-stage source registers
//   d_in_mc_op_en                  decode instruction uses the multi-cycle unit
//   e_in_r1_key/r2_key/rd_key      execute-stage sources and destination
//   e_in_rd_is_load_en             execute instruction is a load
//   e_in_branch_en                 taken branch/jump resolved in execute
//   e_in_mc_issue_en               execute instruction enters the mc unit
//   m_in_rd_key/m_in_rd_we         memory-stage write port
//   wb_in_rd_key/wb_in_rd_we       writeback-stage write port
//   mc_in_done_en/mc_in_rd_key     multi-cycle result valid and destination
//   hu_out_alu_src1_sel/src2_sel   forwarding selects (see fwd_sel_t)
//   hu_out_stall_f_en/stall_d_en   hold PC and IF/ID
//   hu_out_flush_d_en/flush_e_en   bubble IF/ID and ID/EX
//   hu_out_mc_busy                 multi-cycle unit occupied
//   hu_out_stall_cnt               saturating count of stall cycles
// All outputs read 0 while rst is asserted.
// ---------------------------------------------------------------------------
module hazard_unit_sb
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HU_REG_ADDR_W,
    parameter int NUM_REGS   = 2 ** REG_ADDR_W,
    parameter int CNT_W      = HU_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] d_in_r1_key,
    input  logic [REG_ADDR_W-1:0] d_in_r2_key,
    input  logic                  d_in_mc_op_en,
    input  logic [REG_ADDR_W-1:0] e_in_r1_key,
    input  logic [REG_ADDR_W-1:0] e_in_r2_key,
    input  logic [REG_ADDR_W-1:0] e_in_rd_key,
    input  logic                  e_in_rd_is_load_en,
    input  logic                  e_in_branch_en,
    input  logic                  e_in_mc_issue_en,
    input  logic [REG_ADDR_W-1:0] m_in_rd_key,
    input  logic                  m_in_rd_we,
    input  logic [REG_ADDR_W-1:0] wb_in_rd_key,
    input  logic                  wb_in_rd_we,
    input  logic                  mc_in_done_en,
    input  logic [REG_ADDR_W-1:0] mc_in_rd_key,
    output logic [1:0]            hu_out_alu_src1_sel,
    output logic [1:0]            hu_out_alu_src2_sel,
    output logic                  hu_out_stall_f_en,
    output logic                  hu_out_stall_d_en,
    output logic                  hu_out_flush_d_en,
    output logic                  hu_out_flush_e_en,
    output logic                  hu_out_mc_busy,
    output logic [CNT_W-1:0]      hu_out_stall_cnt
);

    mc_state_t        mc_state;
    logic             wrong_path;
    logic             issue_live;
    logic             done_eff;
    logic             issue_ok;
    logic             sb_r1_busy;
    logic             sb_r2_busy;
    logic             load_stall;
    logic             sb_stall;
    logic             mc_stall;
    logic             stall;
    fwd_sel_t         src1_sel;
    fwd_sel_t         src2_sel;
    logic [CNT_W-1:0] stall_cnt;

    // Forwarding priority: the youngest producer (memory stage) wins, then a
    // completing multi-cycle result, then writeback. x0 never forwards.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] m_key,
        input logic                  m_we,
        input logic                  mc_done,
        input logic [REG_ADDR_W-1:0] mc_key,
        input logic [REG_ADDR_W-1:0] wb_key,
        input logic                  wb_we
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (m_we && (m_key == src)) begin
                sel = FWD_MEM;
            end else if (mc_done && (mc_key == src)) begin
                sel = FWD_MC;
            end else if (wb_we && (wb_key == src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

`ifdef HU_MC_FLUSH_EN
    logic branch_q;

    // Remember last cycle's taken branch so the instruction that follows it
    // into execute (the wrong-path one) cannot claim the multi-cycle unit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_q <= 1'b0;
        end else begin
            branch_q <= e_in_branch_en;
        end
    end

    assign wrong_path = branch_q;
`else
    assign wrong_path = 1'b0;
`endif

    // An issue is accepted when the unit is free or is handing back its
    // result on this same edge. Issue into a busy unit and done from an idle
    // unit are protocol errors and are ignored here.
    assign issue_live = e_in_mc_issue_en && !wrong_path;
    assign done_eff   = mc_in_done_en && (mc_state == BUSY);
    assign issue_ok   = issue_live && ((mc_state == IDLE) || done_eff);

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_REGS   (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_ok),
        .set_key  (e_in_rd_key),
        .clr_en   (done_eff),
        .clr_key  (mc_in_rd_key),
        .rd1_key  (d_in_r1_key),
        .rd2_key  (d_in_r2_key),
        .rd1_busy (sb_r1_busy),
        .rd2_busy (sb_r2_busy)
    );

    // Operand forwarding selects for the two execute-stage sources.
    always_comb begin
        src1_sel = fwd_select(e_in_r1_key, m_in_rd_key, m_in_rd_we, mc_in_done_en,
                              mc_in_rd_key, wb_in_rd_key, wb_in_rd_we);
        src2_sel = fwd_select(e_in_r2_key, m_in_rd_key, m_in_rd_we, mc_in_done_en,
                              mc_in_rd_key, wb_in_rd_key, wb_in_rd_we);
    end

    // Stall sources: a load result is not ready for the next instruction,
    // a source is still owed by the multi-cycle unit, or a second multi-cycle
    // op arrives while the unit is occupied and not finishing this cycle.
    always_comb begin
        load_stall = e_in_rd_is_load_en && (e_in_rd_key != '0) &&
                     ((e_in_rd_key == d_in_r1_key) || (e_in_rd_key == d_in_r2_key));
        sb_stall   = sb_r1_busy || sb_r2_busy;
        mc_stall   = d_in_mc_op_en && (mc_state == BUSY) && !mc_in_done_en;
        stall      = load_stall || sb_stall || mc_stall;
    end

    // Multi-cycle unit occupancy. Done together with a new issue keeps the
    // unit BUSY so back-to-back operations do not bounce through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_state <= IDLE;
        end else begin
            case (mc_state)
                IDLE: begin
                    if (issue_ok) begin
                        mc_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done_eff && !issue_ok) begin
                        mc_state <= IDLE;
                    end
                end
                default: mc_state <= IDLE;
            endcase
        end
    end

    // Performance counter of stalled cycles; it sticks at all-ones rather
    // than wrapping so a long run never reports a misleadingly small value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // The pipeline registers give flush priority over stall, so a taken
    // branch may raise both flush_d and stall_d in the same cycle.
    assign hu_out_alu_src1_sel = rst ? FWD_RF : src1_sel;
    assign hu_out_alu_src2_sel = rst ? FWD_RF : src2_sel;
    assign hu_out_stall_f_en   = stall && !rst;
    assign hu_out_stall_d_en   = stall && !rst;
    assign hu_out_flush_d_en   = e_in_branch_en && !rst;
    assign hu_out_flush_e_en   = (stall || e_in_branch_en) && !rst;
    assign hu_out_mc_busy      = (mc_state == BUSY);
    assign hu_out_stall_cnt    = stall_cnt;

    // Protocol checks on the multi-cycle handshake and issue/branch overlap.
    a_issue_while_busy : assert property (@(posedge clk) disable iff (rst)
        !(issue_live && (mc_state == BUSY) && !mc_in_done_en));
    a_done_while_idle : assert property (@(posedge clk) disable iff (rst)
        !(mc_in_done_en && (mc_state == IDLE)));
    a_issue_with_branch : assert property (@(posedge clk) disable iff (rst)
        !(e_in_mc_issue_en && e_in_branch_en));

endmodule
